serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_pkg.sv | 16 +
 rtl/bit_timer.sv | 30 +++
 rtl/serial_frame_tx.sv | 115 +++++++++++
 tb/tb_serial_frame_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial transmitter: state encoding and
// frame-level constants.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE      = 1'b1;
  localparam int   FRAME_OVERHEAD = 3;

endpackage

// File: rtl/bit_timer.sv
// Modulo-BIT_CYCLES counter with synchronous clear; tick marks the last cycle
// of each serial bit period while enabled.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, even parity,
// stop bit. All line outputs are registered from the next-state values.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  input_clock1_1,
  input  logic                  input_reset2_2,
  input  logic                  input_start3_3,
  input  logic [DATA_WIDTH-1:0] input_data4_4,
  output logic                  output_txd_5,
  output logic                  output_txd_n_6,
  output logic                  output_busy_7,
  output logic                  output_done_8,
  output state_t                output_dbg_state_9
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic                  parity, parity_nxt;
  logic                  start_prev;
  logic                  accept;
  logic                  tick;
  logic                  txd_nxt;
  logic                  done_nxt;

  // Only an edge seen while idle starts a frame; others are dropped.
  assign accept = input_start3_3 && !start_prev && (state == IDLE);

  assign output_dbg_state_9 = state;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (input_clock1_1),
    .rst  (input_reset2_2),
    .clear(accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          shreg_nxt   = input_data4_4;
          parity_nxt  = ^input_data4_4;
          bit_cnt_nxt = '0;
        end
      end
      START:  if (tick) state_nxt = DATA;
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg >> 1;
          end
        end
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line value for the state being entered, so txd is aligned with state.
  always_comb begin
    txd_nxt = LINE_IDLE;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shreg_nxt[0];
      PARITY:  txd_nxt = parity_nxt;
      default: txd_nxt = LINE_IDLE;
    endcase
    done_nxt = (state == STOP) && (state_nxt == IDLE);
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset2_2) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      parity         <= 1'b0;
      start_prev     <= 1'b1;
      output_txd_5   <= LINE_IDLE;
      output_txd_n_6 <= ~LINE_IDLE;
      output_busy_7  <= 1'b0;
      output_done_8  <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      bit_cnt        <= bit_cnt_nxt;
      parity         <= parity_nxt;
      start_prev     <= input_start3_3;
      output_txd_5   <= txd_nxt;
      output_txd_n_6 <= ~txd_nxt;
      output_busy_7  <= (state_nxt != IDLE);
      output_done_8  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (1 and 3 clocks per bit) share one
// stimulus stream and are checked every cycle against a frame-position model.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data;

  logic   txd_a, txd_n_a, busy_a, done_a;
  logic   txd_b, txd_n_b, busy_b, done_b;
  state_t dbg_a, dbg_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // clock / reset block
  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(1)) dut_a (
    .input_clock1_1    (clk),
    .input_reset2_2    (rst),
    .input_start3_3    (start),
    .input_data4_4     (data),
    .output_txd_5      (txd_a),
    .output_txd_n_6    (txd_n_a),
    .output_busy_7     (busy_a),
    .output_done_8     (done_a),
    .output_dbg_state_9(dbg_a)
  );

  serial_frame_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(3)) dut_b (
    .input_clock1_1    (clk),
    .input_reset2_2    (rst),
    .input_start3_3    (start),
    .input_data4_4     (data),
    .output_txd_5      (txd_b),
    .output_txd_n_6    (txd_n_b),
    .output_busy_7     (busy_b),
    .output_done_8     (done_b),
    .output_dbg_state_9(dbg_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: expected outputs follow from the position inside the frame.
  int         m_bc[2] = '{1, 3};
  bit         m_active[2];
  int         m_k[2];
  logic [3:0] m_word[2];
  bit         m_prev[2];
  logic [3:0] exp_q_a[$];
  logic [3:0] exp_q_b[$];

  function automatic logic frame_bit(input logic [DW-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (idx == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) begin
      int         f;
      int         rel;
      logic       e_txd, e_busy, e_done;
      logic [3:0] e;
      f = (DW + FRAME_OVERHEAD) * m_bc[i];
      if (r) begin
        m_active[i] = 1'b0;
        m_prev[i]   = 1'b1;
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        if (s && !m_prev[i] && (!m_active[i] || (cyc - 1 - m_k[i] >= f))) begin
          m_active[i] = 1'b1;
          m_k[i]      = cyc;
          m_word[i]   = d;
        end
        m_prev[i] = s;
        rel = cyc - m_k[i];
        if (m_active[i] && rel < f) begin
          e_txd = frame_bit(m_word[i], rel / m_bc[i]); e_busy = 1'b1; e_done = 1'b0;
        end else begin
          e_txd = 1'b1; e_busy = 1'b0; e_done = m_active[i] && (rel == f);
        end
      end
      e = {~e_txd, e_txd, e_busy, e_done};
      if (i == 0) exp_q_a.push_back(e);
      else        exp_q_b.push_back(e);
    end
  endtask

  task automatic score_one(input string nm, input logic [3:0] e, input logic t,
                           input logic tn, input logic b, input logic dn, input state_t st);
    check_eq({nm, "_txd"}, t, e[2]);
    check_eq({nm, "_txd_n"}, tn, e[3]);
    check_eq({nm, "_busy"}, b, e[1]);
    check_eq({nm, "_done"}, dn, e[0]);
    check_eq({nm, "_state_idle"}, st == IDLE, !e[1]);
  endtask

  // driver task: apply inputs, clock once, predict, compare away from the edge
  task automatic step(input logic r, input logic s, input logic [DW-1:0] d);
    rst = r; start = s; data = d;
    @(posedge clk);
    cyc++;
    model_step(r, s, d);
    #1;
    score_one("a", exp_q_a.pop_front(), txd_a, txd_n_a, busy_a, done_a, dbg_a);
    score_one("b", exp_q_b.pop_front(), txd_b, txd_n_b, busy_b, done_b, dbg_b);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [6:0] rec_txd;
    logic [7:0] rec_done;
    int         cnt;
    int         done_at;
    int         n_done_a, n_done_b;

    // reset with start held high: no frame afterwards
    repeat (3) step(1'b1, 1'b1, 4'h0);
    check_eq("rst_state", dbg_a, IDLE);
    check_eq("rst_txd", txd_a, 1'b1);
    check_eq("rst_txd_n", txd_n_b, 1'b0);
    cnt = 0;
    repeat (4) begin step(1'b0, 1'b1, 4'h0); cnt += busy_a + busy_b; end
    check_eq("held_start_no_frame", cnt, 0);
    idle_n(3);

    // basic frame 1011
    rec_txd = '0; rec_done = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i == 0, 4'b1011);
      if (i < 7) rec_txd[i] = txd_a;
      rec_done[i] = done_a;
    end
    check_eq("basic_txd_seq", rec_txd, 7'b1110110);
    check_eq("basic_done_seq", rec_done, 8'b1000_0000);
    idle_n(20);

    // parity zero case, data input scrambled mid-frame
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i == 0, (i == 0) ? 4'b0110 : 4'($urandom_range(0, 15)));
      if (i == 5) check_eq("par0_parity", txd_a, 1'b0);
      if (i == 6) check_eq("par0_stop", txd_a, 1'b1);
    end
    idle_n(20);

    // stretched bits on the 3-cycle instance
    cnt = 0; done_at = -1;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, i == 0, 4'b0001);
      cnt += busy_b;
      if (done_b) done_at = i;
      if (i == 4) check_eq("stretch_d0", txd_b, 1'b1);
    end
    check_eq("stretch_busy_len", cnt, 21);
    check_eq("stretch_done_at", done_at, 21);
    idle_n(5);

    // long start with mid-frame re-pulse: one frame per instance
    n_done_a = 0; n_done_b = 0;
    for (int i = 0; i < 35; i++) begin
      step(1'b0, (i < 10) && (i != 2), 4'b1100);
      n_done_a += done_a; n_done_b += done_b;
    end
    check_eq("repulse_frames_a", n_done_a, 1);
    check_eq("repulse_frames_b", n_done_b, 1);

    // start edge on the STOP->IDLE edge is ignored
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i == 0) || (i == 7), 4'b0101);
      if (i == 7) check_eq("b2b_coincident_ignored", busy_a, 1'b0);
    end
    idle_n(25);

    // start edge one cycle later is accepted
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i == 0) || (i == 8), 4'b0101);
      if (i == 8) check_eq("b2b_next_accepted", busy_a, 1'b1);
    end
    idle_n(25);

    // reset mid-frame with start held through it
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1 && (i == 0 || i > 0), 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    check_eq("midrst_txd", txd_a, 1'b1);
    check_eq("midrst_busy", busy_a, 1'b0);
    check_eq("midrst_done", done_a, 1'b0);
    cnt = 0;
    repeat (10) begin step(1'b0, 1'b1, 4'b1111); cnt += busy_a + busy_b + done_a + done_b; end
    check_eq("midrst_no_frame", cnt, 0);
    step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);
    check_eq("midrst_restart", busy_a, 1'b1);
    idle_n(25);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic s;
      s = ($urandom_range(0, 3) == 0) ? ~start : start;
      step($urandom_range(0, 149) == 0, s, 4'($urandom_range(0, 15)));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
